serial_sub_fsm: RTL

//  Bit-serial N-bit subtractor computing diff = a - b - bin, LSB first.

---
 rtl/serial_sub_pkg.sv | 13 +
 rtl/fs_cell.sv | 14 +
 rtl/serial_sub_fsm.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
// Provides the FSM state encoding and the default operand width.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SERIAL_SUB_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/fs_cell.sv
// One-bit full subtractor: d = x - y - bi, bo = borrow out.
// Ports: x, y, bi in; d, bo out. Purely combinational.
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~x & bi) | (y & bi);

endmodule

// File: rtl/serial_sub_fsm.sv
// Bit-serial WIDTH-bit subtractor diff = a - b - bin, LSB first,
// with valid/ready handshakes on operand and result sides.
// Ports: clk, rst (sync, active high); in_valid/in_ready/a/b/bin;
// out_valid/out_ready/diff/bout; ovf only with SERIAL_SUB_OVF_EN.
module serial_sub_fsm
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SERIAL_SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             bout,
  output logic             ovf
`else
  output logic             bout
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             d_bit;
  logic             bo_bit;
  logic             last;
  logic [WIDTH-1:0] res_sh;

  fs_cell u_fs (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .bi (br_q),
    .d  (d_bit),
    .bo (bo_bit)
  );

  assign last   = (cnt_q == CW'(WIDTH - 1));
  // new bit enters at the MSB; works for WIDTH=1 too
  assign res_sh = (res_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = bo_bit;
        res_d = res_sh;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          diff_d  = res_sh;
          bout_d  = bo_bit;
`ifdef SERIAL_SUB_OVF_EN
          // a_q[0]/b_q[0] hold the operand MSBs here
          ovf_d   = (a_q[0] ^ b_q[0]) & (a_q[0] ^ d_bit);
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = ~rst & (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
